// File: rtl/reg_linear_mac.sv
// Multi-feature linear estimator: predict = bias + sum(w[i]*x[i]) over a valid/ready feature stream,
// one MAC per cycle, with a loadable coefficient bank and a saturated, registered result.
module reg_linear_mac #(
  parameter int FEAT_W    = 16,
  parameter int COEF_W    = 16,
  parameter int MAX_PARAM = 8,
  parameter int ACC_W     = 40,
  parameter int OUT_W     = 32,
  localparam int AW       = $clog2(MAX_PARAM + 1)
) (
  input  logic              clk,
  input  logic              r0,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              start,
  input  logic [7:0]        n_param,
  input  logic              feat_valid,
  input  logic [FEAT_W-1:0] feat_data,
  output logic              feat_ready,
  output logic [OUT_W-1:0]  predict,
  output logic              r,
  output logic              busy,
  output logic              sat,
  output logic              err
);
  localparam int PROD_W = FEAT_W + COEF_W + 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [7:0] MAX_N   = 8'(MAX_PARAM);

  logic [1:0]              state_q, state_d;
  logic [7:0]              n_q, n_d;
  logic [7:0]              idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    err_lat_q, err_lat_d;
  logic [COEF_W-1:0]       bias_q, bias_d;
  logic [COEF_W-1:0]       w_q [MAX_PARAM];
  logic [COEF_W-1:0]       w_d [MAX_PARAM];
  logic [OUT_W-1:0]        predict_q, predict_d;
  logic                    r_q, r_d;
  logic                    busy_q, busy_d;
  logic                    sat_q, sat_d;
  logic                    err_q, err_d;
  logic                    feat_ready_q, feat_ready_d;

  logic [COEF_W-1:0]        w_sel;
  logic signed [PROD_W-1:0] feat_x, w_x, prod;
  logic signed [ACC_W-1:0]  prod_ext, bias_ext;
  logic [OUT_W:0]           sat_pack;

  // Clamp to the signed OUT_W range; the top bit of the result flags a clamp.
  function automatic logic [OUT_W:0] sat_fn(input logic [ACC_W-1:0] a);
    logic [ACC_W-OUT_W:0] top;
    logic [OUT_W:0]       res;
    top = a[ACC_W-1:OUT_W-1];
    if ((&top) || (~|top)) begin
      res = {1'b0, a[OUT_W-1:0]};
    end else if (a[ACC_W-1]) begin
      res = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      res = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    end
    return res;
  endfunction

  // Weight selection and signed product of the zero-extended feature.
  always_comb begin
    w_sel = {COEF_W{1'b0}};
    for (int i = 0; i < MAX_PARAM; i++) begin
      w_sel = (idx_q == 8'(i)) ? w_q[i] : w_sel;
    end
    feat_x   = {{(COEF_W + 1){1'b0}}, feat_data};
    w_x      = {{(FEAT_W + 1){w_sel[COEF_W-1]}}, w_sel};
    prod     = feat_x * w_x;
    prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    bias_ext = {{(ACC_W - COEF_W){bias_q[COEF_W-1]}}, bias_q};
  end

  // Next-state, coefficient bank and output-register logic.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    err_lat_d = err_lat_q;
    bias_d    = bias_q;
    w_d       = w_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d       = (n_param > MAX_N) ? MAX_N : n_param;
          err_lat_d = (n_param > MAX_N);
          acc_d     = bias_ext;
          idx_d     = 8'd0;
          state_d   = (n_d == 8'd0) ? S_DONE : S_ACCUM;
        end else if (coef_we) begin
          // Addresses beyond the bank simply match nothing.
          bias_d = (coef_addr == {AW{1'b0}}) ? coef_data : bias_q;
          for (int i = 0; i < MAX_PARAM; i++) begin
            w_d[i] = (coef_addr == AW'(i + 1)) ? coef_data : w_q[i];
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (feat_valid) begin
          acc_d = acc_q + prod_ext;
          idx_d = idx_q + 8'd1;
          if (idx_q == n_q - 8'd1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ACCUM;
          end
        end else begin
          state_d = S_ACCUM;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    sat_pack     = sat_fn(acc_d);
    r_d          = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
    feat_ready_d = (state_d == S_ACCUM);
    // Result registers load on entry to DONE so they are valid alongside r.
    if (state_d == S_DONE) begin
      predict_d = sat_pack[OUT_W-1:0];
      sat_d     = sat_pack[OUT_W];
      err_d     = err_lat_d;
    end else begin
      predict_d = predict_q;
      sat_d     = sat_q;
      err_d     = err_q;
    end
  end

  // State, datapath, coefficient bank and output flops.
  always_ff @(posedge clk or negedge r0) begin
    if (!r0) begin
      state_q      <= S_IDLE;
      n_q          <= 8'd0;
      idx_q        <= 8'd0;
      acc_q        <= {ACC_W{1'b0}};
      err_lat_q    <= 1'b0;
      bias_q       <= {COEF_W{1'b0}};
      for (int i = 0; i < MAX_PARAM; i++) begin
        w_q[i] <= {COEF_W{1'b0}};
      end
      predict_q    <= {OUT_W{1'b0}};
      r_q          <= 1'b0;
      busy_q       <= 1'b0;
      sat_q        <= 1'b0;
      err_q        <= 1'b0;
      feat_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      err_lat_q    <= err_lat_d;
      bias_q       <= bias_d;
      w_q          <= w_d;
      predict_q    <= predict_d;
      r_q          <= r_d;
      busy_q       <= busy_d;
      sat_q        <= sat_d;
      err_q        <= err_d;
      feat_ready_q <= feat_ready_d;
    end
  end

  assign predict    = predict_q;
  assign r          = r_q;
  assign busy       = busy_q;
  assign sat        = sat_q;
  assign err        = err_q;
  assign feat_ready = feat_ready_q;

endmodule
